// File: rtl/fetch_queue_if.sv
// Handshake bundle between the IF stage, the fetch queue and the ID stage.
// The queue takes the slave modport; the IF/ID side takes master.
interface fetch_queue_if #(
   parameter int WORD_LEN  = 32,
   parameter int ADDR_BITS = 2
);
   logic [WORD_LEN-1:0]  IF_PC;
   logic [WORD_LEN-1:0]  IF_INSTRUCTION;
   logic                 IF_VALID;
   logic                 FLUSH;
   logic                 ID_READY;
   logic                 ID_VALID;
   logic [WORD_LEN-1:0]  ID_PC;
   logic [WORD_LEN-1:0]  ID_INSTRUCTION;
   logic                 FREEZE;
   logic [ADDR_BITS:0]   COUNT;

   modport master (
      output IF_PC, IF_INSTRUCTION, IF_VALID, FLUSH, ID_READY,
      input  ID_VALID, ID_PC, ID_INSTRUCTION, FREEZE, COUNT
   );

   modport slave (
      input  IF_PC, IF_INSTRUCTION, IF_VALID, FLUSH, ID_READY,
      output ID_VALID, ID_PC, ID_INSTRUCTION, FREEZE, COUNT
   );
endinterface

// File: rtl/fetch_queue.sv
// Circular-buffer decoupling queue between instruction fetch and decode.
// FREEZE back-pressures IF when full; FLUSH discards every queued entry.
module fetch_queue #(
   parameter int WORD_LEN  = 32,
   parameter int DEPTH     = 4,
   parameter int ADDR_BITS = 2
) (
   input  logic          CLK,
   input  logic          RESET,
   fetch_queue_if.slave  bus
);

   localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic [WORD_LEN-1:0]  pc_mem_q    [DEPTH];
   logic [WORD_LEN-1:0]  instr_mem_q [DEPTH];

   logic full;
   logic not_empty;
   logic push;
   logic pop;

   assign full      = (count_q == FULL_COUNT);
   assign not_empty = (count_q != '0);
   // Full blocks the push even when a pop frees a slot this cycle.
   assign push      = bus.IF_VALID && !full && !bus.FLUSH;
   assign pop       = not_empty && bus.ID_READY && !bus.FLUSH;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
         if (push && !pop)      count_d = count_q + (ADDR_BITS+1)'(1);
         else if (pop && !push) count_d = count_q - (ADDR_BITS+1)'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= bus.IF_PC;
         instr_mem_q[wr_ptr_q] <= bus.IF_INSTRUCTION;
      end
   end

   // Storage survives a flush, so the head is masked whenever the queue is empty.
   assign bus.ID_VALID       = not_empty;
   assign bus.ID_PC          = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
   assign bus.ID_INSTRUCTION = not_empty ? instr_mem_q[rd_ptr_q] : '0;
   assign bus.FREEZE         = full;
   assign bus.COUNT          = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_fetch_queue;

   localparam int WL    = 32;
   localparam int DEPTH = 4;
   localparam int AB    = 2;

   logic CLK = 1'b0;
   logic RESET;

   fetch_queue_if #(.WORD_LEN(WL), .ADDR_BITS(AB)) bus ();

   fetch_queue #(.WORD_LEN(WL), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        fl;
      logic        rdy;
      int          e_cnt;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic        e_frz;
   } vec_t;

   ent_t mq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string nm);
      chk({nm, "_count"},  32'(bus.COUNT), 32'(mq.size()));
      chk({nm, "_valid"},  32'(bus.ID_VALID), 32'(mq.size() != 0));
      chk({nm, "_pc"},     bus.ID_PC, (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk({nm, "_instr"},  bus.ID_INSTRUCTION, (mq.size() != 0) ? mq[0].ins : 32'h0);
      chk({nm, "_freeze"}, 32'(bus.FREEZE), 32'(mq.size() == DEPTH));
   endtask

   // Drive one cycle, advance the model by the queue rules, then compare.
   task automatic tick(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic rdy, input string nm);
      ent_t e;
      bit   was_full;
      bus.IF_VALID       = iv;
      bus.IF_PC          = pc;
      bus.IF_INSTRUCTION = ins;
      bus.FLUSH          = fl;
      bus.ID_READY       = rdy;
      was_full = (mq.size() == DEPTH);
      if (fl) begin
         mq.delete();
      end else begin
         if (rdy && mq.size() != 0) void'(mq.pop_front());
         if (iv && !was_full) begin
            e.pc  = pc;
            e.ins = ins;
            mq.push_back(e);
         end
      end
      @(posedge CLK);
      #1;
      chk_model(nm);
   endtask

   function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                               input logic rdy, input int cnt, input logic [31:0] epc,
                               input logic [31:0] eins);
      vec_t v;
      v.iv = iv; v.pc = pc; v.ins = ins; v.fl = 1'b0; v.rdy = rdy;
      v.e_cnt = cnt; v.e_vld = (cnt != 0); v.e_pc = epc; v.e_ins = eins;
      v.e_frz = (cnt == DEPTH);
      return v;
   endfunction

   vec_t vec[14];

   initial begin
      // Fill to full, reject a 5th push, drain two, wrap, drain all, pop on empty.
      vec[0]  = mk(1, 32'h00, 32'hA0, 0, 1, 32'h00, 32'hA0);
      vec[1]  = mk(1, 32'h04, 32'hA1, 0, 2, 32'h00, 32'hA0);
      vec[2]  = mk(1, 32'h08, 32'hA2, 0, 3, 32'h00, 32'hA0);
      vec[3]  = mk(1, 32'h0C, 32'hA3, 0, 4, 32'h00, 32'hA0);
      vec[4]  = mk(1, 32'h10, 32'hA4, 0, 4, 32'h00, 32'hA0);
      vec[5]  = mk(0, 32'h00, 32'h00, 1, 3, 32'h04, 32'hA1);
      vec[6]  = mk(0, 32'h00, 32'h00, 1, 2, 32'h08, 32'hA2);
      vec[7]  = mk(1, 32'h10, 32'hA4, 0, 3, 32'h08, 32'hA2);
      vec[8]  = mk(1, 32'h14, 32'hA5, 0, 4, 32'h08, 32'hA2);
      vec[9]  = mk(0, 32'h00, 32'h00, 1, 3, 32'h0C, 32'hA3);
      vec[10] = mk(0, 32'h00, 32'h00, 1, 2, 32'h10, 32'hA4);
      vec[11] = mk(0, 32'h00, 32'h00, 1, 1, 32'h14, 32'hA5);
      vec[12] = mk(0, 32'h00, 32'h00, 1, 0, 32'h00, 32'h00);
      vec[13] = mk(0, 32'h00, 32'h00, 1, 0, 32'h00, 32'h00);

      RESET = 1'b0;
      bus.IF_VALID = 1'b0; bus.IF_PC = '0; bus.IF_INSTRUCTION = '0;
      bus.FLUSH = 1'b0; bus.ID_READY = 1'b0;
      #2;
      chk("rst_valid",  32'(bus.ID_VALID), 32'h0);
      chk("rst_pc",     bus.ID_PC, 32'h0);
      chk("rst_freeze", 32'(bus.FREEZE), 32'h0);
      chk("rst_count",  32'(bus.COUNT), 32'h0);
      #10;
      RESET = 1'b1;

      for (int i = 0; i < 14; i++) begin
         tick(vec[i].iv, vec[i].pc, vec[i].ins, vec[i].fl, vec[i].rdy, "vec");
         chk("vec_cnt",   32'(bus.COUNT), 32'(vec[i].e_cnt));
         chk("vec_vld",   32'(bus.ID_VALID), 32'(vec[i].e_vld));
         chk("vec_pc",    bus.ID_PC, vec[i].e_pc);
         chk("vec_ins",   bus.ID_INSTRUCTION, vec[i].e_ins);
         chk("vec_frz",   32'(bus.FREEZE), 32'(vec[i].e_frz));
      end

      // Simultaneous push and pop at COUNT=2.
      tick(1, 32'h20, 32'hB0, 0, 0, "sim_fill");
      tick(1, 32'h24, 32'hB1, 0, 0, "sim_fill");
      for (int k = 0; k < 6; k++) begin
         tick(1, 32'h28 + 32'(4*k), 32'hB2 + 32'(k), 0, 1, "sim");
         chk("sim_cnt", 32'(bus.COUNT), 32'd2);
         chk("sim_pc",  bus.ID_PC, 32'h24 + 32'(4*k));
      end

      // Full with a concurrent pop: the IF entry waits one cycle.
      tick(0, 32'h0, 32'h0, 1, 0, "fp_flush");
      for (int k = 0; k < 4; k++) tick(1, 32'h50 + 32'(4*k), 32'hC0 + 32'(k), 0, 0, "fp_fill");
      tick(1, 32'h60, 32'hCF, 0, 1, "fp_pop");
      chk("fp_cnt3",  32'(bus.COUNT), 32'd3);
      chk("fp_frz0",  32'(bus.FREEZE), 32'd0);
      chk("fp_head",  bus.ID_PC, 32'h54);
      tick(1, 32'h60, 32'hCF, 0, 0, "fp_push");
      chk("fp_cnt4",  32'(bus.COUNT), 32'd4);
      chk("fp_frz1",  32'(bus.FREEZE), 32'd1);
      for (int k = 0; k < 3; k++) tick(0, 32'h0, 32'h0, 0, 1, "fp_drain");
      chk("fp_last",  bus.ID_PC, 32'h60);

      // Flush with concurrent push and pop at COUNT=3.
      tick(1, 32'h64, 32'hC1, 0, 0, "fl_fill");
      tick(1, 32'h68, 32'hC2, 0, 0, "fl_fill");
      tick(1, 32'h6C, 32'hC3, 1, 1, "fl");
      chk("fl_cnt",  32'(bus.COUNT), 32'd0);
      chk("fl_vld",  32'(bus.ID_VALID), 32'd0);
      chk("fl_frz",  32'(bus.FREEZE), 32'd0);
      tick(1, 32'h40, 32'hD0, 0, 0, "fl_push");
      chk("fl_head_vld", 32'(bus.ID_VALID), 32'd1);
      chk("fl_head_pc",  bus.ID_PC, 32'h40);

      // Asynchronous reset mid-run at COUNT=3.
      tick(1, 32'h44, 32'hD1, 0, 0, "ar_fill");
      tick(1, 32'h48, 32'hD2, 0, 0, "ar_fill");
      chk("ar_pre_cnt", 32'(bus.COUNT), 32'd3);
      #2;
      RESET = 1'b0;
      #1;
      mq.delete();
      chk("ar_valid", 32'(bus.ID_VALID), 32'h0);
      chk("ar_pc",    bus.ID_PC, 32'h0);
      chk("ar_ins",   bus.ID_INSTRUCTION, 32'h0);
      chk("ar_frz",   32'(bus.FREEZE), 32'h0);
      chk("ar_cnt",   32'(bus.COUNT), 32'h0);
      @(negedge CLK);
      RESET = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(0, 32'h0, 32'h0, 0, 1, "ar_idle");
         chk("ar_idle_vld", 32'(bus.ID_VALID), 32'h0);
         chk("ar_idle_cnt", 32'(bus.COUNT), 32'h0);
      end

      // Randomized traffic against the reference model.
      for (int k = 0; k < 400; k++) begin
         tick($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
